// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD sequential writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    IDLE      = 3'd1,
    SETUP     = 3'd2,
    PULSE     = 3'd3,
    SETTLE    = 3'd4
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_FUNCSET = 8'h38;
  localparam logic [7:0] CMD_DISPON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;

  // Number of commands in the power-up sequence.
  localparam int INIT_LEN = 4;

  // Power-up command list: 8-bit bus/2 lines, display on, increment mode, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNCSET;
      2'd1:    cmd = CMD_DISPON;
      2'd2:    cmd = CMD_ENTRY;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Clear and home commands need the long post-pulse wait.
  function automatic logic needs_long_settle(input logic rs, input logic [7:0] b);
    return (rs == 1'b0) && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_r;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/lcd_seq_writer.sv
// Writes command/character byte sequences to a parallel LCD with enable
// strobe timing; optionally runs the controller power-up sequence first.
module lcd_seq_writer
  import lcd_pkg::*;
#(
  parameter int DATA_BYTES     = 4,
  parameter int EN_HIGH_CYCLES = 25,
  parameter int SETTLE_CYCLES  = 2500,
  parameter int CLEAR_CYCLES   = 82000,
  parameter int INIT_EN        = 1,
  parameter int POWERUP_CYCLES = 750000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_rs,
  input  logic [$clog2(DATA_BYTES+1)-1:0] req_len,
  input  logic [8*DATA_BYTES-1:0]         req_data,
  output logic                            rw,
  output logic                            rs,
  output logic                            en,
  output logic [7:0]                      display,
  output logic                            busy
);

  localparam int LW   = $clog2(DATA_BYTES+1);
  localparam int MAXB = (DATA_BYTES > INIT_LEN) ? DATA_BYTES : INIT_LEN;
  localparam int IW   = $clog2(MAXB+1);
  localparam int M1   = (EN_HIGH_CYCLES > SETTLE_CYCLES) ? EN_HIGH_CYCLES : SETTLE_CYCLES;
  localparam int M2   = (CLEAR_CYCLES > POWERUP_CYCLES) ? CLEAR_CYCLES : POWERUP_CYCLES;
  localparam int MAXT = (M1 > M2) ? M1 : M2;
  localparam int TW   = $clog2(MAXT+1);

  // Timer reload values are "cycles - 1"; the power-up value also absorbs the arming cycle.
  localparam logic [TW-1:0] T_EN      = TW'(EN_HIGH_CYCLES - 1);
  localparam logic [TW-1:0] T_SETTLE  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_CLEAR   = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] T_POWERUP = TW'((POWERUP_CYCLES > 2) ? POWERUP_CYCLES - 2 : 0);

  lcd_state_e              state_r, state_nxt_s;
  logic [IW-1:0]           idx_r, idx_nxt_s, idx_inc_s, len_r, len_nxt_s, cur_len_s, req_len_c_s;
  logic [8*DATA_BYTES-1:0] data_r, data_nxt_s;
  logic [7:0]              display_r, disp_nxt_s, data_byte_s;
  logic                    rs_r, rs_nxt_s, en_r, ready_r, busy_r, ready_nxt_s;
  logic                    init_r, init_nxt_s, armed_r, armed_nxt_s, accept_s;
  logic                    tmr_load_s, tmr_done_s;
  logic [TW-1:0]           tmr_val_s;

  lcd_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  assign accept_s    = req_valid && ready_r;
  assign idx_inc_s   = idx_r + {{(IW-1){1'b0}}, 1'b1};
  assign cur_len_s   = init_r ? IW'(INIT_LEN) : len_r;
  assign req_len_c_s = (req_len > LW'(DATA_BYTES)) ? IW'(DATA_BYTES) : IW'(req_len);
  assign ready_nxt_s = (state_r == IDLE) && !accept_s;

  // Select the request byte that follows the current one.
  always_comb begin
    data_byte_s = 8'h00;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (IW'(k) == idx_inc_s) begin
        data_byte_s = data_r[8*k +: 8];
      end else begin
        data_byte_s = data_byte_s;
      end
    end
  end

  // Next-state, byte sequencing and timer control.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    len_nxt_s   = len_r;
    data_nxt_s  = data_r;
    rs_nxt_s    = rs_r;
    disp_nxt_s  = display_r;
    init_nxt_s  = init_r;
    armed_nxt_s = armed_r;
    tmr_load_s  = 1'b0;
    tmr_val_s   = {TW{1'b0}};
    case (state_r)
      INIT_WAIT: begin
        if (INIT_EN == 0) begin
          state_nxt_s = IDLE;
        end else if (!armed_r && (POWERUP_CYCLES > 1)) begin
          armed_nxt_s = 1'b1;
          tmr_load_s  = 1'b1;
          tmr_val_s   = T_POWERUP;
        end else if (!armed_r || tmr_done_s) begin
          state_nxt_s = SETUP;
          armed_nxt_s = 1'b0;
          init_nxt_s  = 1'b1;
          idx_nxt_s   = {IW{1'b0}};
          rs_nxt_s    = 1'b0;
          disp_nxt_s  = CMD_FUNCSET;
        end else begin
          state_nxt_s = INIT_WAIT;
        end
      end
      IDLE: begin
        if (accept_s) begin
          data_nxt_s = req_data;
          len_nxt_s  = req_len_c_s;
          idx_nxt_s  = {IW{1'b0}};
          init_nxt_s = 1'b0;
          if (req_len_c_s != {IW{1'b0}}) begin
            state_nxt_s = SETUP;
            rs_nxt_s    = req_rs;
            disp_nxt_s  = req_data[7:0];
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        state_nxt_s = PULSE;
        tmr_load_s  = 1'b1;
        tmr_val_s   = T_EN;
      end
      PULSE: begin
        if (tmr_done_s) begin
          state_nxt_s = SETTLE;
          tmr_load_s  = 1'b1;
          tmr_val_s   = needs_long_settle(rs_r, display_r) ? T_CLEAR : T_SETTLE;
        end else begin
          state_nxt_s = PULSE;
        end
      end
      SETTLE: begin
        if (tmr_done_s && (idx_inc_s < cur_len_s)) begin
          state_nxt_s = SETUP;
          idx_nxt_s   = idx_inc_s;
          disp_nxt_s  = init_r ? init_cmd(idx_inc_s[1:0]) : data_byte_s;
        end else if (tmr_done_s) begin
          state_nxt_s = IDLE;
          init_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      default: begin
        state_nxt_s = INIT_WAIT;
      end
    endcase
  end

  // State and registered LCD/handshake outputs; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= INIT_WAIT;
      idx_r     <= {IW{1'b0}};
      len_r     <= {IW{1'b0}};
      data_r    <= {(8*DATA_BYTES){1'b0}};
      rs_r      <= 1'b0;
      display_r <= 8'h00;
      en_r      <= 1'b0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b1;
      init_r    <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      len_r     <= len_nxt_s;
      data_r    <= data_nxt_s;
      rs_r      <= rs_nxt_s;
      display_r <= disp_nxt_s;
      en_r      <= (state_nxt_s == PULSE);
      ready_r   <= ready_nxt_s;
      busy_r    <= !ready_nxt_s;
      init_r    <= init_nxt_s;
      armed_r   <= armed_nxt_s;
    end
  end

  assign rw        = 1'b0;
  assign rs        = rs_r;
  assign en        = en_r;
  assign display   = display_r;
  assign req_ready = ready_r;
  assign busy      = busy_r;

endmodule
